// File: rtl/tri_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tri_bus_arbiter
// Round-robin arbiter that drives the per-buffer enables of a bank of tri-state
// buffers sharing one bus. A grant is held for at most HOLD cycles while others
// wait, and successive owners are separated by one turnaround cycle with every
// enable low, so two buffers never drive the bus at the same time.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset
//   req    in   [NREQ]  level-sensitive request per requester
//   en     out  [NREQ]  one-hot (or zero) buffer enables, registered
//   owner  out  [OWNW]  index of current owner, meaningful only while busy=1
//   busy   out          high while any en bit is high
//   turn   out          high during the turnaround cycle
// -----------------------------------------------------------------------------
module tri_bus_arbiter #(
    parameter int NREQ = 4,
    parameter int HOLD = 4,
    parameter int OWNW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] en,
    output logic [OWNW-1:0] owner,
    output logic            busy,
    output logic            turn
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam logic [OWNW-1:0] LAST_IDX = OWNW'(NREQ - 1);
    localparam logic [3:0]      HOLD_MAX = 4'(HOLD);

    state_t            state_r;
    logic [OWNW-1:0]   rr_ptr_r;
    logic [3:0]        hold_r;

    logic              found_s;
    logic [OWNW-1:0]   pick_s;
    logic [NREQ-1:0]   pick_mask_s;
    logic [NREQ-1:0]   owner_mask_s;
    logic              others_pending_s;
    logic [OWNW-1:0]   next_ptr_s;

    // Round-robin search: first requesting index at or above rr_ptr_r, wrapping.
    // Scanning from the farthest offset down lets the nearest hit win.
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(rr_ptr_r) + i) % NREQ;
            if (req[idx]) begin
                found_s = 1'b1;
                pick_s  = OWNW'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Masks for the chosen winner, the current owner, and the pointer past the owner.
    always_comb begin
        pick_mask_s      = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
        owner_mask_s     = {{(NREQ-1){1'b0}}, 1'b1} << owner;
        others_pending_s = |(req & ~owner_mask_s);
        if (owner == LAST_IDX) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = owner + OWNW'(1);
        end
    end

    // Arbiter FSM with registered enables and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= '0;
            hold_r   <= 4'd0;
            en       <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            turn     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_TURN: begin
                    // Both states grant straight from the pointer; a requester
                    // that dropped during TURN simply is not seen here.
                    if (found_s) begin
                        state_r <= ST_GRANT;
                        en      <= pick_mask_s;
                        owner   <= pick_s;
                        hold_r  <= 4'd1;
                        busy    <= 1'b1;
                        turn    <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        en      <= '0;
                        busy    <= 1'b0;
                        turn    <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!req[owner] || ((hold_r == HOLD_MAX) && others_pending_s)) begin
                        state_r  <= ST_TURN;
                        en       <= '0;
                        busy     <= 1'b0;
                        turn     <= 1'b1;
                        rr_ptr_r <= next_ptr_s;
                    end else if (hold_r == HOLD_MAX) begin
                        // Sole requester: restart the hold window, no gap on the bus.
                        hold_r <= 4'd1;
                    end else begin
                        hold_r <= hold_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    en      <= '0;
                    busy    <= 1'b0;
                    turn    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tri_bus_arbiter
// Directed self-checking bench for tri_bus_arbiter (NREQ=4, HOLD=4, OWNW=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_tri_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] en;
    logic [1:0] owner;
    logic       busy;
    logic       turn;

    int n_checks;
    int n_pass;

    tri_bus_arbiter #(.NREQ(4), .HOLD(4), .OWNW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .en    (en),
        .owner (owner),
        .busy  (busy),
        .turn  (turn)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check, reports mismatches.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] exp_en, input logic exp_turn);
        chk({tag, ".en"},   {28'd0, en},   {28'd0, exp_en});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, (exp_en != 4'd0)});
        chk({tag, ".turn"}, {31'd0, turn}, {31'd0, exp_turn});
        chk({tag, ".oh0"},  {31'd0, $onehot0(en)}, 32'd1);
    endtask

    task automatic chk_owner(input string tag, input logic [1:0] exp_owner);
        chk({tag, ".owner"}, {30'd0, owner}, {30'd0, exp_owner});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        req      = 4'b0000;

        // Reset state and single request.
        step();
        step();
        chk_out("rst", 4'b0000, 1'b0);
        reset = 1'b0;
        req   = 4'b0100;
        step();
        chk_out("single", 4'b0100, 1'b0);
        chk_owner("single", 2'd2);
        req = 4'b0000;
        step();
        chk_out("single_turn", 4'b0000, 1'b1);
        step();
        chk_out("single_idle", 4'b0000, 1'b0);

        // Sole long request keeps the bus with no turnaround (pointer is 3 here).
        req = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            step();
            chk_out("sole", 4'b0001, 1'b0);
            chk_owner("sole", 2'd0);
        end
        req = 4'b0000;
        step();
        chk_out("sole_turn", 4'b0000, 1'b1);
        step();
        chk_out("sole_idle", 4'b0000, 1'b0);

        // Round-robin with all requesting, starting from pointer 0.
        do_reset();
        req = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            for (int o = 0; o < 4; o++) begin
                for (int h = 0; h < 4; h++) begin
                    step();
                    chk_out("rr_grant", 4'b0001 << o, 1'b0);
                    chk_owner("rr_grant", 2'(o));
                end
                step();
                chk_out("rr_turn", 4'b0000, 1'b1);
            end
        end
        req = 4'b0000;
        step();
        chk_out("rr_idle", 4'b0000, 1'b0);

        // Early release and pointer advance.
        do_reset();
        req = 4'b0011;
        step();
        chk_out("early_g0a", 4'b0001, 1'b0);
        step();
        chk_out("early_g0b", 4'b0001, 1'b0);
        req = 4'b0010;
        step();
        chk_out("early_turn", 4'b0000, 1'b1);
        step();
        chk_out("early_g1", 4'b0010, 1'b0);
        chk_owner("early_g1", 2'd1);
        req = 4'b0011;
        for (int h = 0; h < 3; h++) begin
            step();
            chk_out("early_g1_hold", 4'b0010, 1'b0);
        end
        step();
        chk_out("early_turn2", 4'b0000, 1'b1);
        step();
        chk_out("early_g0_again", 4'b0001, 1'b0);
        chk_owner("early_g0_again", 2'd0);

        // Move the grant to requester 3 (pointer becomes 1), then reset mid-grant.
        req = 4'b1000;
        step();
        chk_out("pre_async_turn", 4'b0000, 1'b1);
        step();
        chk_out("pre_async_g3", 4'b1000, 1'b0);
        chk_owner("pre_async_g3", 2'd3);
        #2;
        reset = 1'b1;
        #1;
        chk_out("async_clear", 4'b0000, 1'b0);
        step();
        chk_out("async_hold", 4'b0000, 1'b0);
        // Pointer restarted at 0: with 1001 requester 0 wins (pointer 1 would pick 3).
        req   = 4'b1001;
        reset = 1'b0;
        step();
        chk_out("async_regrant", 4'b0001, 1'b0);
        chk_owner("async_regrant", 2'd0);

        // Request withdrawn during turnaround.
        req = 4'b0011;
        for (int h = 0; h < 3; h++) begin
            step();
            chk_out("wd_hold", 4'b0001, 1'b0);
        end
        step();
        chk_out("wd_turn", 4'b0000, 1'b1);
        req = 4'b0000;
        step();
        chk_out("wd_idle", 4'b0000, 1'b0);
        step();
        chk_out("wd_idle2", 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
